// File: rtl/picobello_fixture_top.sv
// Preload and end-of-computation controller for the picobello system fixture.
// Host write beats land in a local L2 SRAM model or a small control register file.
module picobello_fixture_top #(
  parameter int unsigned          DataWidth  = 64,
  parameter int unsigned          AddrWidth  = 48,
  parameter int unsigned          MemWords   = 1024,
  parameter logic [AddrWidth-1:0] MemBase    = 48'h7000_0000,
  parameter logic [AddrWidth-1:0] RegBase    = 48'h0300_0000,
  parameter int unsigned          NumTiles   = 16,
  parameter int unsigned          BurstBytes = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             boot_mode_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic                   wr_first_i,
  input  logic [AddrWidth-1:0]   wr_addr_i,
  input  logic [DataWidth-1:0]   wr_data_i,
  input  logic [DataWidth/8-1:0] wr_strb_i,
  input  logic                   wr_last_i,
  input  logic [AddrWidth-1:0]   rd_addr_i,
  output logic [DataWidth-1:0]   rd_data_o,
  output logic [NumTiles-1:0]    tile_en_o,
  output logic [63:0]            entry_o,
  output logic                   launch_o,
  output logic                   eoc_o,
  output logic [31:0]            exit_code_o,
  output logic                   err_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxW      = $clog2(MemWords);
  localparam int unsigned MaxBeats  = BurstBytes / 8;
  localparam int unsigned BeatW     = $clog2(MaxBeats + 1);
  localparam int unsigned PageW     = AddrWidth - 12;
  localparam logic [AddrWidth-1:0] MemBytes = AddrWidth'(MemWords * 8);
  localparam logic [AddrWidth-1:0] RegBytes = AddrWidth'(64);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] cur_addr_q, cur_addr_d;
  logic [PageW-1:0]     page_q, page_d;
  logic [BeatW-1:0]     beats_q, beats_d;
  logic [3:0]           stall_q, stall_d;
  logic                 ready_q;

  logic [NumTiles-1:0]  tile_en_q;
  logic [DataWidth-1:0] entry_q, scratch_q;
  logic                 launch_q, eoc_q, err_q;
  logic [31:0]          exit_code_q;

  logic [DataWidth-1:0] mem_q [MemWords];

  logic                 accept, tracked, seq_err, beat_ok, beat_err;
  logic                 stall_hold, stall_err;
  logic [AddrWidth-1:0] beat_addr;
  logic [PageW-1:0]     beat_page;
  logic [BeatW-1:0]     beat_idx;
  logic [AddrWidth-1:0] wr_mem_off, wr_reg_off, rd_mem_off, rd_reg_off;
  logic                 wr_in_mem, wr_in_reg, rd_in_mem, rd_in_reg;
  logic                 mem_we, reg_we, tile_wr, entry_wr, scratch_wr;
  logic [2:0]           reg_sel;
  logic [DataWidth-1:0] strb_mask, entry_new, scratch_new;
  logic [NumTiles-1:0]  tile_new;

  // ready_q keeps the port low for the first cycle after reset is released
  assign wr_ready_o = rst_ni & ready_q & (boot_mode_i == 2'd0);
  assign accept     = wr_valid_i & wr_ready_o;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    page_d     = page_q;
    beats_d    = beats_q;
    seq_err    = 1'b0;
    tracked    = 1'b0;
    beat_addr  = cur_addr_q;
    beat_page  = page_q;
    beat_idx   = beats_q;
    if (accept) begin
      if (wr_first_i) begin
        tracked   = 1'b1;
        beat_addr = wr_addr_i;
        beat_page = wr_addr_i[AddrWidth-1:12];
        beat_idx  = '0;
        seq_err   = (state_q == StBurst);
        state_d   = wr_last_i ? StIdle : StBurst;
      end else if (state_q == StBurst) begin
        tracked = 1'b1;
        state_d = wr_last_i ? StIdle : StBurst;
      end else begin
        seq_err = 1'b1;
      end
      // Address advances even over dropped beats so later beats keep their slots
      if (tracked) begin
        cur_addr_d = beat_addr + AddrWidth'(8);
        page_d     = beat_page;
        beats_d    = (beat_idx == BeatW'(MaxBeats)) ? beat_idx : beat_idx + BeatW'(1);
      end
    end
  end

  assign beat_ok = (beat_addr[2:0] == 3'd0) && (beat_addr[AddrWidth-1:12] == beat_page) &&
                   (beat_idx < BeatW'(MaxBeats));

  assign wr_mem_off = beat_addr - MemBase;
  assign wr_reg_off = beat_addr - RegBase;
  assign wr_in_mem  = (beat_addr >= MemBase) && (wr_mem_off < MemBytes);
  assign wr_in_reg  = (beat_addr >= RegBase) && (wr_reg_off < RegBytes);
  assign mem_we     = tracked && beat_ok && wr_in_mem;
  assign reg_we     = tracked && beat_ok && wr_in_reg;
  assign beat_err   = tracked && !(beat_ok && (wr_in_mem || wr_in_reg));

  assign reg_sel    = wr_reg_off[5:3];
  assign tile_wr    = reg_we && (reg_sel == 3'd0);
  assign entry_wr   = reg_we && (reg_sel == 3'd1);
  assign scratch_wr = reg_we && (reg_sel == 3'd2);

  always_comb begin
    strb_mask = '0;
    for (int i = 0; i < StrbWidth; i++) strb_mask[8*i +: 8] = {8{wr_strb_i[i]}};
  end

  assign tile_new    = (tile_en_q & ~strb_mask[NumTiles-1:0]) |
                       (wr_data_i[NumTiles-1:0] & strb_mask[NumTiles-1:0]);
  assign entry_new   = (entry_q & ~strb_mask) | (wr_data_i & strb_mask);
  assign scratch_new = (scratch_q & ~strb_mask) | (wr_data_i & strb_mask);

  // A beat parked while preload is disabled flags an error after 16 cycles
  assign stall_hold = wr_valid_i && (boot_mode_i != 2'd0);
  assign stall_err  = stall_hold && (stall_q == 4'd15);
  assign stall_d    = !stall_hold ? 4'd0 : (stall_q == 4'd15) ? stall_q : stall_q + 4'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      page_q      <= '0;
      beats_q     <= '0;
      stall_q     <= '0;
      ready_q     <= 1'b0;
      tile_en_q   <= '0;
      entry_q     <= '0;
      scratch_q   <= '0;
      launch_q    <= 1'b0;
      eoc_q       <= 1'b0;
      exit_code_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      page_q     <= page_d;
      beats_q    <= beats_d;
      stall_q    <= stall_d;
      ready_q    <= 1'b1;
      launch_q   <= entry_wr;
      if (tile_wr)  tile_en_q <= tile_new;
      if (entry_wr) entry_q   <= entry_new;
      if (scratch_wr) begin
        scratch_q <= scratch_new;
        if (scratch_new[0]) begin
          eoc_q       <= 1'b1;
          exit_code_q <= scratch_new[32:1];
        end
      end
      if (seq_err || beat_err || stall_err) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < StrbWidth; i++) begin
        if (wr_strb_i[i]) mem_q[wr_mem_off[IdxW+2:3]][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  assign rd_mem_off = rd_addr_i - MemBase;
  assign rd_reg_off = rd_addr_i - RegBase;
  assign rd_in_mem  = (rd_addr_i >= MemBase) && (rd_mem_off < MemBytes);
  assign rd_in_reg  = (rd_addr_i >= RegBase) && (rd_reg_off < RegBytes);

  always_comb begin
    rd_data_o = '0;
    if (rd_in_mem) begin
      rd_data_o = mem_q[rd_mem_off[IdxW+2:3]];
    end else if (rd_in_reg) begin
      case (rd_reg_off[5:3])
        3'd0:    rd_data_o = DataWidth'(tile_en_q);
        3'd1:    rd_data_o = entry_q;
        3'd2:    rd_data_o = scratch_q;
        3'd3:    rd_data_o = DataWidth'(boot_mode_i);
        default: rd_data_o = '0;
      endcase
    end
  end

  assign tile_en_o   = tile_en_q;
  assign entry_o     = entry_q;
  assign launch_o    = launch_q;
  assign eoc_o       = eoc_q;
  assign exit_code_o = exit_code_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_picobello_fixture_top.sv
// Bench for picobello_fixture_top: directed scenarios plus randomized bursts,
// all compared cycle by cycle against a behavioural model of SRAM, registers and flags.
module tb_picobello_fixture_top;

  localparam logic [47:0] MemBase    = 48'h7000_0000;
  localparam logic [47:0] RegBase    = 48'h0300_0000;
  localparam int          MemWords   = 1024;
  localparam int          BurstBytes = 256;
  localparam logic [47:0] MemBytes   = 48'(MemWords * 8);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  boot_mode;
  logic        valid, ready, first, last;
  logic [47:0] addr, rd_addr;
  logic [63:0] data, rd_data, entry;
  logic [7:0]  strb;
  logic [15:0] tile_en;
  logic        launch, eoc, err;
  logic [31:0] exit_code;

  always #5 clk = ~clk;

  picobello_fixture_top dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .boot_mode_i (boot_mode),
    .wr_valid_i  (valid),
    .wr_ready_o  (ready),
    .wr_first_i  (first),
    .wr_addr_i   (addr),
    .wr_data_i   (data),
    .wr_strb_i   (strb),
    .wr_last_i   (last),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .tile_en_o   (tile_en),
    .entry_o     (entry),
    .launch_o    (launch),
    .eoc_o       (eoc),
    .exit_code_o (exit_code),
    .err_o       (err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_mem [MemWords];
  logic [15:0] m_tile;
  logic [63:0] m_entry, m_scratch;
  logic [31:0] m_exit;
  logic        m_launch, m_eoc, m_err;
  bit          m_in_burst;
  logic [47:0] m_next, m_page;
  int          m_bytes, m_hold;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_rd(input logic [47:0] a);
    logic [47:0] off;
    if (a >= MemBase && a < MemBase + MemBytes) return m_mem[int'((a - MemBase) >> 3)];
    off = a - RegBase;
    if (a >= RegBase && off < 48'd64) begin
      case (int'(off >> 3))
        0:       return {48'h0, m_tile};
        1:       return m_entry;
        2:       return m_scratch;
        3:       return {62'h0, boot_mode};
        default: return 64'h0;
      endcase
    end
    return 64'h0;
  endfunction

  // Applies the accepted beat currently on the write inputs
  task automatic model_beat();
    logic [47:0] a, off;
    logic [63:0] mrg;
    bit          legal;
    if (first) begin
      if (m_in_burst) m_err = 1'b1;
      a          = addr;
      m_page     = addr >> 12;
      m_bytes    = 0;
      m_in_burst = !last;
    end else if (!m_in_burst) begin
      m_err = 1'b1;
      return;
    end else begin
      a          = m_next;
      m_in_burst = !last;
    end
    m_next  = a + 48'd8;
    m_bytes = m_bytes + 8;
    legal   = (a % 8 == 0) && ((a >> 12) == m_page) && (m_bytes <= BurstBytes);
    if (!legal) begin
      m_err = 1'b1;
    end else if (a >= MemBase && a < MemBase + MemBytes) begin
      m_mem[int'((a - MemBase) >> 3)] = merge(m_mem[int'((a - MemBase) >> 3)], data, strb);
    end else if (a >= RegBase && a - RegBase < 48'd64) begin
      off = a - RegBase;
      case (int'(off >> 3))
        0: begin
          mrg    = merge({48'h0, m_tile}, data, strb);
          m_tile = mrg[15:0];
        end
        1: begin
          m_entry  = merge(m_entry, data, strb);
          m_launch = 1'b1;
        end
        2: begin
          m_scratch = merge(m_scratch, data, strb);
          if (m_scratch[0]) begin
            m_eoc  = 1'b1;
            m_exit = m_scratch[32:1];
          end
        end
        default: ;
      endcase
    end else begin
      m_err = 1'b1;
    end
  endtask

  // One clock: read before the edge sees old data, then everything is compared after it
  task automatic step();
    #1;
    check_eq("rd_pre", rd_data, model_rd(rd_addr));
    @(posedge clk);
    #1;
    m_launch = 1'b0;
    if (valid && boot_mode != 2'd0) begin
      m_hold++;
      if (m_hold >= 16) m_err = 1'b1;
    end else begin
      m_hold = 0;
    end
    if (valid && boot_mode == 2'd0) model_beat();
    check_eq("ready", 64'(ready), 64'(boot_mode == 2'd0));
    check_eq("err", 64'(err), 64'(m_err));
    check_eq("eoc", 64'(eoc), 64'(m_eoc));
    check_eq("exit_code", 64'(exit_code), 64'(m_exit));
    check_eq("launch", 64'(launch), 64'(m_launch));
    check_eq("tile_en", 64'(tile_en), 64'(m_tile));
    check_eq("entry", entry, m_entry);
    check_eq("rd_post", rd_data, model_rd(rd_addr));
  endtask

  task automatic beat(input bit f, input logic [47:0] a, input logic [63:0] d,
                      input logic [7:0] s, input bit l);
    valid = 1'b1;
    first = f;
    addr  = a;
    data  = d;
    strb  = s;
    last  = l;
    step();
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    first = 1'b0;
    last  = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    valid     = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    boot_mode = 2'd0;
    rst_n     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(ready), 64'h0);
    check_eq("rst_tile", 64'(tile_en), 64'h0);
    check_eq("rst_entry", entry, 64'h0);
    check_eq("rst_launch", 64'(launch), 64'h0);
    check_eq("rst_eoc", 64'(eoc), 64'h0);
    check_eq("rst_exit", 64'(exit_code), 64'h0);
    check_eq("rst_err", 64'(err), 64'h0);
    m_tile = '0; m_entry = '0; m_scratch = '0; m_exit = '0;
    m_launch = 1'b0; m_eoc = 1'b0; m_err = 1'b0;
    m_in_burst = 1'b0; m_bytes = 0; m_hold = 0;
    rst_n = 1'b1;
    #1;
    check_eq("ready_rel", 64'(ready), 64'h0);
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", 64'(ready), 64'h1);
  endtask

  function automatic logic [47:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return RegBase + 48'(8 * $urandom_range(0, 8));
    return MemBase + 48'(8 * $urandom_range(0, MemWords + 7));
  endfunction

  // mode 0: zeros, 1: 0x11*(n+1) pattern, 2: random data/strobes/read address
  task automatic burst(input logic [47:0] a, input int n, input int mode);
    logic [63:0] d;
    logic [7:0]  s;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       d = 64'h0;
        1:       d = 64'h11 * 64'(i + 1);
        default: d = {$urandom, $urandom};
      endcase
      s = (mode == 2 && $urandom_range(0, 1) == 1) ? 8'($urandom) : 8'hFF;
      if (mode == 2) rd_addr = ($urandom_range(0, 1) == 1) ? a + 48'(8 * i) : rand_addr();
      beat(i == 0, a, d, s, i == n - 1);
    end
  endtask

  initial begin
    rd_addr = MemBase;
    addr = '0; data = '0; strb = '0;
    for (int i = 0; i < MemWords; i++) m_mem[i] = 64'h0;
    do_reset();

    // Zero the SRAM so the model starts from known contents
    for (int b = 0; b < MemWords / 32; b++) burst(MemBase + 48'(256 * b), 32, 0);
    idle(1);

    rd_addr = MemBase + 48'h118;
    burst(MemBase + 48'h100, 4, 1);
    idle(1);
    check_eq("burst4_rd", rd_data, 64'h44);
    check_eq("burst4_err", 64'(err), 64'h0);

    rd_addr = MemBase;
    beat(1'b1, MemBase, 64'hAABBCCDD_11223344, 8'h0F, 1'b1);
    idle(1);
    check_eq("partial_strb", rd_data, 64'h00000000_11223344);

    rd_addr = RegBase;
    beat(1'b1, RegBase, 64'h3, 8'hFF, 1'b1);
    beat(1'b1, RegBase + 48'h8, 64'h8000_0000, 8'hFF, 1'b1);
    check_eq("launch_hi", 64'(launch), 64'h1);
    idle(1);
    check_eq("launch_lo", 64'(launch), 64'h0);
    check_eq("tile_en_3", 64'(tile_en), 64'h3);
    check_eq("entry_val", entry, 64'h8000_0000);

    rd_addr = RegBase + 48'h10;
    beat(1'b1, RegBase + 48'h10, 64'h55, 8'hFF, 1'b1);
    check_eq("eoc_set", 64'(eoc), 64'h1);
    check_eq("exit_42", 64'(exit_code), 64'd42);
    beat(1'b1, RegBase + 48'h10, 64'h0, 8'hFF, 1'b1);
    idle(1);
    check_eq("eoc_sticky", 64'(eoc), 64'h1);
    check_eq("exit_kept", 64'(exit_code), 64'd42);
    rd_addr = RegBase + 48'h20;
    idle(1);
    check_eq("reg_unmapped", rd_data, 64'h0);

    do_reset();
    rd_addr = MemBase + 48'h1000;
    burst(MemBase + 48'hFF8, 2, 1);
    idle(1);
    check_eq("x4k_err", 64'(err), 64'h1);
    rd_addr = MemBase + 48'hFF8;
    idle(1);
    check_eq("x4k_first", rd_data, 64'h11);

    do_reset();
    rd_addr = MemBase + 48'h500;
    burst(MemBase + 48'h400, 33, 1);
    idle(1);
    check_eq("burst_len_err", 64'(err), 64'h1);

    do_reset();
    rd_addr = MemBase + 48'h700;
    beat(1'b1, MemBase + 48'h600, 64'h1234, 8'hFF, 1'b0);
    beat(1'b1, MemBase + 48'h700, 64'h5678, 8'hFF, 1'b1);
    idle(1);
    check_eq("restart_err", 64'(err), 64'h1);
    check_eq("restart_data", rd_data, 64'h5678);

    do_reset();
    rd_addr = MemBase + MemBytes;
    idle(1);
    check_eq("oor_rd", rd_data, 64'h0);
    check_eq("oor_rd_err", 64'(err), 64'h0);
    beat(1'b1, 48'h1000, 64'h1, 8'hFF, 1'b1);
    check_eq("oor_wr_err", 64'(err), 64'h1);

    do_reset();
    rd_addr = MemBase + 48'h308;
    beat(1'b1, MemBase + 48'h300, 64'hCAFE, 8'hFF, 1'b0);
    do_reset();
    beat(1'b0, MemBase + 48'h300, 64'hBEEF, 8'hFF, 1'b1);
    check_eq("orphan_err", 64'(err), 64'h1);

    do_reset();
    boot_mode = 2'd2;
    rd_addr = RegBase + 48'h18;
    for (int i = 0; i < 15; i++) beat(1'b1, MemBase, 64'hFFFF, 8'hFF, 1'b1);
    check_eq("stall_ready", 64'(ready), 64'h0);
    check_eq("stall_err_15", 64'(err), 64'h0);
    beat(1'b1, MemBase, 64'hFFFF, 8'hFF, 1'b1);
    check_eq("stall_err_16", 64'(err), 64'h1);
    boot_mode = 2'd0;
    idle(1);

    for (int e = 0; e < 15; e++) begin
      do_reset();
      for (int k = 0; k < 6; k++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5:
            burst(MemBase - 48'h40 + 48'(8 * $urandom_range(0, MemWords + 15)),
                  $urandom_range(1, 5), 2);
          6: begin
            rd_addr = RegBase + 48'(8 * $urandom_range(0, 3));
            beat(1'b1, RegBase + 48'(8 * $urandom_range(0, 8)), {$urandom, $urandom},
                 8'($urandom), 1'b1);
          end
          7: beat(1'b1, MemBase + 48'(8 * $urandom_range(0, 100) + $urandom_range(1, 7)),
                  {$urandom, $urandom}, 8'hFF, 1'b1);
          8: beat(1'b0, rand_addr(), {$urandom, $urandom}, 8'hFF, 1'b1);
          default: begin
            boot_mode = 2'($urandom_range(1, 3));
            repeat ($urandom_range(1, 20)) beat(1'b1, MemBase, 64'h77, 8'hFF, 1'b1);
            boot_mode = 2'd0;
          end
        endcase
        rd_addr = rand_addr();
        idle($urandom_range(0, 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
